// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers (poly 0x11B) for the
// inverse MixColumns / AddRoundKey datapath.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } fsm_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Higher multiples are built from the x2/x4/x8 ladder of xtime.
    function automatic byte_t gmul9(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic byte_t gmul11(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic byte_t gmul13(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic byte_t gmul14(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic int get_byte_hi(input int k);
        return 127 - 8 * k;
    endfunction

    function automatic int get_byte_lo(input int k);
        return 120 - 8 * k;
    endfunction

endpackage

// File: rtl/aes_inv_mix_add_inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; a0 is the most
// significant byte.
module inv_mix_column
    import aes_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);

    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];

        b0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        b1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        b2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        b3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

        col_out = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/aes_inv_mix_add.sv
// AddRoundKey followed by InvMixColumns, one column per cycle by default.
// Define AES_INV_MIX_PARALLEL_EN to transform all four columns in one cycle.
module aes_inv_mix_add
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    fsm_t   state_q;
    fsm_t   state_d;
    state_t work;

`ifdef AES_INV_MIX_PARALLEL_EN
    state_t mixed_all;

    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_cols
        inv_mix_column u_col (
            .col_in  (work[get_byte_hi(4 * gc) -: 32]),
            .col_out (mixed_all[get_byte_hi(4 * gc) -: 32])
        );
    end
`else
    localparam int CNT_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    logic [CNT_W-1:0] col_cnt;
    col_t             cur_col;
    col_t             mixed_col;

    always_comb begin
        cur_col = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_cnt == CNT_W'(c)) begin
                cur_col = work[get_byte_hi(4 * c) -: 32];
            end
        end
    end

    inv_mix_column u_col (
        .col_in  (cur_col),
        .col_out (mixed_col)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = last_round ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
`ifdef AES_INV_MIX_PARALLEL_EN
                state_d = DONE;
`else
                if (col_cnt == LAST_COL) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The work register holds key-mixed state and is transformed in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
`ifndef AES_INV_MIX_PARALLEL_EN
            col_cnt <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work <= state_in ^ round_key;
                    end
`ifndef AES_INV_MIX_PARALLEL_EN
                    col_cnt <= '0;
`endif
                end
                COMPUTE: begin
`ifdef AES_INV_MIX_PARALLEL_EN
                    work <= mixed_all;
`else
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (col_cnt == CNT_W'(c)) begin
                            work[get_byte_hi(4 * c) -: 32] <= mixed_col;
                        end
                    end
                    col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Ready is masked by reset so nothing is offered while rst_n is low.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = out_valid ? work : '0;

endmodule

// File: tb/tb_aes_inv_mix_add.sv
// Directed and model-checked bench for aes_inv_mix_add; latency expectation
// follows AES_INV_MIX_PARALLEL_EN.
module tb_aes_inv_mix_add;

`ifdef AES_INV_MIX_PARALLEL_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_inv_mix_add dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .round_key  (round_key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply, independent of the RTL helpers.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
            r[119 - 32 * c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
            r[111 - 32 * c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
            r[103 - 32 * c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
        return r;
    endfunction

    task automatic applyStimulus(input string tag, input logic [127:0] st, input logic [127:0] key,
                                 input logic last, input logic [127:0] exp, input int exp_lat);
        int lat;
        int waitc;
        @(negedge clk);
        state_in   = st;
        round_key  = key;
        last_round = last;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checkOutput({tag, "_ready"}, 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        state_in   = ~st;
        round_key  = ~key;
        last_round = ~last;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 30);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        checkOutput({tag, "_data"}, data_out, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] st, key, exp, hold;
        logic         last;
        int           waitc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        state_in   = '0;
        round_key  = '0;
        last_round = 1'b0;
        out_ready  = 1'b0;

        #12;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_data_out", data_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 128'(in_ready), 128'(1));

        applyStimulus("vec_db13", {4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'hdb135345}}, EXP_LAT);
        applyStimulus("vec_mixed", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 128'h0, 1'b0,
                      {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, EXP_LAT);
        applyStimulus("vec_last", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                      1'b1, 128'h00102030405060708090a0b0c0d0e0f0, 1);
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        applyStimulus("vec_key", {4{32'h8e4da1bc}} ^ key, key, 1'b0, {4{32'hdb135345}}, EXP_LAT);

        // Stall in DONE while upstream keeps poking the input side.
        @(negedge clk);
        state_in   = {4{32'h8e4da1bc}};
        round_key  = '0;
        last_round = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!out_valid && waitc < 30);
        checkOutput("stall_reach_done", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            state_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checkOutput("stall_data", data_out, {4{32'hdb135345}});
            checkOutput("stall_flags", 128'({out_valid, in_ready}), 128'(2'b10));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall_release", 128'({out_valid, in_ready}), 128'(2'b01));
        @(negedge clk);
        checkOutput("stall_no_capture", 128'({out_valid, in_ready}), 128'(2'b01));

        // Reset while computing.
        @(negedge clk);
        state_in  = {4{32'h8e4da1bc}};
        round_key = '0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifndef AES_INV_MIX_PARALLEL_EN
        @(posedge clk);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_compute_flags", 128'({out_valid, in_ready}), 128'(2'b00));
        checkOutput("rst_compute_data", data_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_rst_c", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 128'h0, 1'b0,
                      {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, EXP_LAT);

        // Reset while holding a result in DONE.
        @(negedge clk);
        state_in   = {4{32'h8e4da1bc}};
        round_key  = '0;
        last_round = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!out_valid && waitc < 30);
        hold = data_out;
        checkOutput("rst_done_pre", hold, {4{32'hdb135345}});
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done_flags", 128'({out_valid, in_ready}), 128'(2'b00));
        checkOutput("rst_done_data", data_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_rst_d", {4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'hdb135345}}, EXP_LAT);

        // Model-checked sweep.
        for (int n = 0; n < 200; n++) begin
            st   = {$urandom, $urandom, $urandom, $urandom};
            key  = {$urandom, $urandom, $urandom, $urandom};
            last = 1'($urandom_range(0, 1));
            exp  = last ? (st ^ key) : inv_mix_ref(st ^ key);
            applyStimulus("rand", st, key, last, exp, last ? 1 : EXP_LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
